// File: rtl/alu_test_sequencer.sv
// Stimulus sequencer for the on-board ALU: steps operand/opcode vectors, captures the
// ALU result one cycle later and shows it as hex on a multiplexed seven-segment display.
module alu_test_sequencer #(
   parameter int WIDTH       = 16,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int STEP_DIV    = 50000000,
   parameter int STRIDE1     = 1,
   parameter int STRIDE2     = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              step,
   input  logic [WIDTH-1:0]  alu_out,
   input  logic [4:0]        alu_flags,
   output logic [WIDTH-1:0]  data1,
   output logic [WIDTH-1:0]  data2,
   output logic [3:0]        opcode1,
   output logic [3:0]        opcode2,
   output logic [4:0]        flags,
   output logic              running,
   output logic [WIDTH-1:0]  vec_count,
   output logic [DIGITS-1:0] selOut,
   output logic [7:0]        bdOut
);

   localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_DIV - 1);
   localparam logic [31:0] STEP_LAST    = 32'(STEP_DIV - 1);
   localparam logic [2:0]  DIGIT_LAST   = 3'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t            state, state_next;
   logic              step_pending, step_pending_next;
   logic              advance;
   logic              capture_pending;
   logic [31:0]       step_timer, step_timer_next;
   logic [WIDTH-1:0]  result, result_next;
   logic [31:0]       refresh_cnt, refresh_next;
   logic [2:0]        digit, digit_next;
   logic [31:0]       res_ext;
   logic [3:0]        nibble;
   logic [DIGITS-1:0] sel_next;
   logic [7:0]        bd_next;

   // Segment pattern {g,f,e,d,c,b,a}, active-low.
   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      case (v)
         4'h0: hex_seg = 7'h40;
         4'h1: hex_seg = 7'h79;
         4'h2: hex_seg = 7'h24;
         4'h3: hex_seg = 7'h30;
         4'h4: hex_seg = 7'h19;
         4'h5: hex_seg = 7'h12;
         4'h6: hex_seg = 7'h02;
         4'h7: hex_seg = 7'h78;
         4'h8: hex_seg = 7'h00;
         4'h9: hex_seg = 7'h10;
         4'hA: hex_seg = 7'h08;
         4'hB: hex_seg = 7'h03;
         4'hC: hex_seg = 7'h46;
         4'hD: hex_seg = 7'h21;
         4'hE: hex_seg = 7'h06;
         default: hex_seg = 7'h0E;
      endcase
   endfunction

   // A step accepted in IDLE/HOLD moves to HOLD immediately; its vector is applied next edge.
   always_comb begin
      state_next        = state;
      step_pending_next = 1'b0;
      step_timer_next   = step_timer;
      advance           = step_pending;
      case (state)
         IDLE, HOLD: begin
            if (stop) begin
               state_next = HOLD;
            end else if (start) begin
               state_next      = RUN;
               step_timer_next = '0;
            end else if (step) begin
               state_next        = HOLD;
               step_pending_next = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_next = HOLD;
            end else if (step_timer == STEP_LAST) begin
               advance         = 1'b1;
               step_timer_next = '0;
            end else begin
               step_timer_next = step_timer + 32'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Display path looks at the next result so new captures show on the capture edge.
   always_comb begin
      refresh_next = refresh_cnt + 32'd1;
      digit_next   = digit;
      if (refresh_cnt == REFRESH_LAST) begin
         refresh_next = '0;
         digit_next   = (digit == DIGIT_LAST) ? 3'd0 : digit + 3'd1;
      end
      result_next = capture_pending ? alu_out : result;
      res_ext     = 32'(result_next);
      nibble      = res_ext[{digit_next, 2'b00} +: 4];
      sel_next    = ~(DIGITS'(1) << digit_next);
      bd_next     = {~((digit_next == 3'd0) && (state_next == RUN)), hex_seg(nibble)};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         running         <= 1'b0;
         step_pending    <= 1'b0;
         step_timer      <= '0;
         capture_pending <= 1'b0;
         data1           <= '0;
         data2           <= '0;
         opcode1         <= '0;
         opcode2         <= '0;
         vec_count       <= '0;
         result          <= '0;
         flags           <= '0;
         refresh_cnt     <= '0;
         digit           <= '0;
         selOut          <= ~DIGITS'(1);
         bdOut           <= 8'hC0;
      end else begin
         state           <= state_next;
         running         <= (state_next == RUN);
         step_pending    <= step_pending_next;
         step_timer      <= step_timer_next;
         capture_pending <= advance;
         if (advance) begin
            {opcode2, opcode1} <= {opcode2, opcode1} + 8'd1;
            vec_count          <= vec_count + WIDTH'(1);
            if ({opcode2, opcode1} == 8'hFF) begin
               data1 <= data1 + WIDTH'(STRIDE1);
               data2 <= data2 + WIDTH'(STRIDE2);
            end
         end
         if (capture_pending) begin
            result <= alu_out;
            flags  <= alu_flags;
         end
         refresh_cnt <= refresh_next;
         digit       <= digit_next;
         selOut      <= sel_next;
         bdOut       <= bd_next;
      end
   end

endmodule

// File: tb/tb_alu_test_sequencer.sv
// Randomised bench for alu_test_sequencer: vector numbers go into a queue, a monitor
// pops them as vec_count moves and checks vectors, captures and display against a model.
module tb_alu_test_sequencer;

   localparam int W = 16;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0, stop = 1'b0, step = 1'b0;
   logic [W-1:0] alu_out, data1, data2, vec_count;
   logic [4:0]   alu_flags, flags;
   logic [3:0]   opcode1, opcode2, sel_out;
   logic         running;
   logic [7:0]   bd_out;

   logic         step8 = 1'b0;
   logic [7:0]   alu_out8 = 8'hAF;
   logic [4:0]   alu_flags8 = 5'h15;
   logic [7:0]   data1_8, data2_8, vec_count8;
   logic [3:0]   opcode1_8, opcode2_8, sel_out8;
   logic [4:0]   flags8;
   logic         running8;
   logic [7:0]   bd_out8;

   alu_test_sequencer #(.WIDTH(16), .DIGITS(4), .REFRESH_DIV(4), .STEP_DIV(8),
                        .STRIDE1(1), .STRIDE2(3)) u_dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .step(step),
      .alu_out(alu_out), .alu_flags(alu_flags), .data1(data1), .data2(data2),
      .opcode1(opcode1), .opcode2(opcode2), .flags(flags), .running(running),
      .vec_count(vec_count), .selOut(sel_out), .bdOut(bd_out));

   alu_test_sequencer #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(4), .STEP_DIV(8),
                        .STRIDE1(1), .STRIDE2(3)) u_dut8 (
      .clock(clock), .reset(reset), .start(1'b0), .stop(1'b0), .step(step8),
      .alu_out(alu_out8), .alu_flags(alu_flags8), .data1(data1_8), .data2(data2_8),
      .opcode1(opcode1_8), .opcode2(opcode2_8), .flags(flags8), .running(running8),
      .vec_count(vec_count8), .selOut(sel_out8), .bdOut(bd_out8));

   // ALU stand-in for the main instance.
   assign alu_out   = data1 + data2;
   assign alu_flags = {data1[0], opcode1};

   // ---------------- clock / reset bookkeeping ----------------
   always #5 clock = ~clock;

   int m = 0;
   always @(posedge clock) begin
      if (reset) m = 0;
      else       m = m + 1;
   end

   // ---------------- reference model ----------------
   int           n_vec = 0, n_bad = 0;
   int           exp_k = 0;
   bit           exp_run = 1'b0;
   logic [31:0]  exp_q[$];
   logic [7:0]   seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   function automatic logic [15:0] m_d1(input int k);
      return 16'((k / 256) * 1);
   endfunction
   function automatic logic [15:0] m_d2(input int k);
      return 16'((k / 256) * 3);
   endfunction
   function automatic logic [7:0] m_op(input int k);
      return 8'(k % 256);
   endfunction
   function automatic logic [15:0] m_res(input int k);
      return m_d1(k) + m_d2(k);
   endfunction
   function automatic logic [4:0] m_flags(input int k);
      logic [15:0] d;
      logic [7:0]  op;
      d  = m_d1(k);
      op = m_op(k);
      return {d[0], op[3:0]};
   endfunction
   function automatic int digit_now();
      return (m / 4) % 4;
   endfunction
   function automatic logic [3:0] exp_sel(input int d);
      logic [3:0] s;
      s    = 4'hF;
      s[d] = 1'b0;
      return s;
   endfunction
   function automatic logic [7:0] exp_bd(input logic [15:0] res, input int d, input bit run);
      logic [7:0] b;
      int         nib;
      nib = int'((res >> (4 * d)) & 16'hF);
      b   = seg_tab[nib];
      if (run && d == 0) b[7] = 1'b0;
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [W-1:0] last_vc = '0, cur_result = '0, pend_result = '0;
   logic [4:0]   cur_flags = '0, pend_flags = '0;
   logic [31:0]  mon_k;
   bit           pend = 1'b0;

   always @(negedge clock) begin
      if (reset) begin
         last_vc    = '0;
         cur_result = '0;
         cur_flags  = '0;
         pend       = 1'b0;
      end else begin
         if (pend) begin
            chk("capture_flags", 32'(flags), 32'(pend_flags));
            chk("capture_display", 32'(bd_out), 32'(exp_bd(pend_result, digit_now(), exp_run)));
            cur_flags  = pend_flags;
            cur_result = pend_result;
            pend       = 1'b0;
         end
         if (vec_count !== last_vc) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_vector", 32'(vec_count), 32'(last_vc));
            end else begin
               mon_k = exp_q.pop_front();
               chk("vec_opcode", 32'({opcode2, opcode1}), 32'(m_op(int'(mon_k))));
               chk("vec_data1", 32'(data1), 32'(m_d1(int'(mon_k))));
               chk("vec_data2", 32'(data2), 32'(m_d2(int'(mon_k))));
               chk("vec_count", 32'(vec_count), 32'(16'(mon_k)));
               chk("flags_hold", 32'(flags), 32'(cur_flags));
               pend        = 1'b1;
               pend_result = m_res(int'(mon_k));
               pend_flags  = m_flags(int'(mon_k));
            end
            last_vc = vec_count;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_reset(input string tag);
      chk({tag, "_data1"}, 32'(data1), 32'h0);
      chk({tag, "_data2"}, 32'(data2), 32'h0);
      chk({tag, "_opcode"}, 32'({opcode2, opcode1}), 32'h0);
      chk({tag, "_flags"}, 32'(flags), 32'h0);
      chk({tag, "_running"}, 32'(running), 32'h0);
      chk({tag, "_vec_count"}, 32'(vec_count), 32'h0);
      chk({tag, "_sel"}, 32'(sel_out), 32'hE);
      chk({tag, "_bd"}, 32'(bd_out), 32'hC0);
   endtask

   task automatic do_reset();
      @(posedge clock); #2 reset = 1'b1;
      @(posedge clock); #2 reset = 1'b0;
      exp_run = 1'b0;
      exp_k   = 0;
      exp_q.delete();
   endtask

   task automatic do_step(input int gap);
      @(posedge clock); #2 step = 1'b1;
      exp_k++;
      exp_q.push_back(32'(exp_k));
      @(posedge clock); #2 step = 1'b0;
      @(negedge clock); chk("step_not_early", 32'(vec_count), 32'(16'(exp_k - 1)));
      @(negedge clock); chk("step_latency", 32'(vec_count), 32'(16'(exp_k)));
      repeat (gap) @(negedge clock);
   endtask

   task automatic run_for(input int n, input bit stop_end, input int step_at);
      @(posedge clock); #2 start = 1'b1;
      @(posedge clock); #2 start = 1'b0;
      exp_run = 1'b1;
      @(negedge clock); chk("running_after_start", 32'(running), 32'h1);
      for (int i = 1; i <= n; i++) begin
         @(posedge clock); #2;
         if (i % 8 == 0) begin
            exp_k++;
            exp_q.push_back(32'(exp_k));
         end
         step = (i == step_at);
         stop = stop_end && (i == n);
         @(negedge clock);
         chk("run_timing", 32'(vec_count), 32'(16'(exp_k)));
         chk("dp_heartbeat", 32'(bd_out[7]), 32'(digit_now() != 0));
      end
      @(posedge clock); #2 stop = 1'b0; step = 1'b0;
      if (stop_end) exp_run = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      check_reset("reset");
      for (int j = 0; j < 17; j++) begin
         @(negedge clock);
         chk("digit_rotate", 32'(sel_out), 32'(exp_sel(digit_now())));
      end

      // three single steps from IDLE, ten cycles apart
      for (int j = 0; j < 3; j++) do_step(8);
      chk("three_steps_opcode1", 32'(opcode1), 32'h3);
      chk("three_steps_running", 32'(running), 32'h0);

      // free run; step mid-run is ignored; stop lands on an advance edge and wins
      run_for(39, 1'b1, 13);
      repeat (10) @(negedge clock);
      chk("stop_no_advance", 32'(vec_count), 32'(16'(exp_k)));
      chk("stop_running", 32'(running), 32'h0);

      // re-entering RUN clears the frozen timer; then reset mid-run
      run_for(11, 1'b0, 0);
      do_reset();
      @(negedge clock);
      check_reset("mid_run_reset");

      // start+stop and step+stop together from IDLE
      @(posedge clock); #2 start = 1'b1; stop = 1'b1;
      @(posedge clock); #2 start = 1'b0; stop = 1'b0;
      repeat (10) @(negedge clock);
      chk("start_stop_running", 32'(running), 32'h0);
      chk("start_stop_no_advance", 32'(vec_count), 32'h0);
      @(posedge clock); #2 step = 1'b1; stop = 1'b1;
      @(posedge clock); #2 step = 1'b0; stop = 1'b0;
      repeat (4) @(negedge clock);
      chk("step_stop_no_advance", 32'(vec_count), 32'h0);

      // 256 steps with random spacing wrap the opcode and bump the data strides
      for (int j = 0; j < 256; j++) do_step($urandom_range(0, 3));
      repeat (2) @(negedge clock);
      chk("wrap_opcode", 32'({opcode2, opcode1}), 32'h0);
      chk("wrap_data1", 32'(data1), 32'h1);
      chk("wrap_data2", 32'(data2), 32'h3);
      chk("wrap_vec_count", 32'(vec_count), 32'd256);
      for (int t = 0; t < 16 && digit_now() != 0; t++) @(negedge clock);
      chk("wrap_digit0_sel", 32'(sel_out), 32'hE);
      chk("wrap_digit0_bd", 32'(bd_out), 32'h99);

      // narrow instance: digits beyond the result width show zero
      @(posedge clock); #2 step8 = 1'b1;
      @(posedge clock); #2 step8 = 1'b0;
      repeat (3) @(negedge clock);
      chk("w8_flags", 32'(flags8), 32'h15);
      for (int d = 0; d < 4; d++) begin
         for (int t = 0; t < 16 && digit_now() != d; t++) @(negedge clock);
         chk("w8_sel", 32'(sel_out8), 32'(exp_sel(d)));
         chk("w8_bd", 32'(bd_out8), 32'(exp_bd({8'h00, 8'hAF}, d, 1'b0) & ((d < 2) ? 8'hFF : 8'hFF)));
      end

      repeat (3) @(negedge clock);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_test_sequencer.md
# alu_test_sequencer

Parametrised stimulus generator and result display for exercising the ALU on the FPGA board. It drives operand and opcode registers into the ALU, then captures the ALU result and flags one cycle after each vector is applied. The captured result is shown as hex on a time-multiplexed DIGITS-wide seven-segment display. It supports free-run, pause and single-step modes, and replaces the fixed one-digit tester arrangement at the top level.

## Interface
Parameters:
- WIDTH, 16, operand/result width; multiple of 4, 4..32
- DIGITS, 4, number of seven-segment digits multiplexed, 1..8
- REFRESH_DIV, 50000, clock cycles each digit is enabled, ≥2
- STEP_DIV, 50000000, clock cycles between vectors in RUN, ≥2
- STRIDE1, 1, increment applied to data1 on opcode wrap
- STRIDE2, 3, increment applied to data2 on opcode wrap

Ports:
- clock  in  1  single system clock; all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse (debounced upstream); enter RUN
- stop  in  1  one-cycle pulse; enter HOLD
- step  in  1  one-cycle pulse; advance exactly one vector, end in HOLD
- alu_out  in  WIDTH  combinational ALU result
- alu_flags  in  5  combinational ALU flags
- data1  out  WIDTH  operand A
- data2  out  WIDTH  operand B
- opcode1  out  4  ALU opcode
- opcode2  out  4  ALU sub-opcode
- flags  out  5  captured flags
- running  out  1  high in RUN
- vec_count  out  WIDTH  vectors applied since reset, wraps mod 2^WIDTH
- selOut  out  DIGITS  digit enables, active-low one-hot
- bdOut  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}

## Operation
- States: IDLE (after reset), RUN, HOLD.
- IDLE/HOLD + start → RUN. RUN/IDLE + stop → HOLD. stop and start in the same cycle: stop wins.
- step is honoured only in IDLE/HOLD. It applies one vector and ends in HOLD. step in RUN is ignored. step with start: start wins. step with stop: stop wins and the step is ignored.
- Vector advance: {opcode2,opcode1} increments by 1 (8-bit wrap). When it wraps 8'hFF→8'h00, data1 += STRIDE1 and data2 += STRIDE2, both mod 2^WIDTH. vec_count increments on the same edge.
- Capture: the cycle after an advance, the result register takes alu_out and flags takes alu_flags. Captured values hold until the next capture.
- Display:
  - The refresh counter counts 0..REFRESH_DIV-1 in every state.
  - On wrap, the digit index advances 0..DIGITS-1 and then returns to 0.
  - Digit i shows result[4i+3:4i]. Digits with 4i ≥ WIDTH show 0.
  - Hex encoding, active-low, dp off: 0→C0, 1→F9, 8→80, A→88, F→8E.
  - dp (bit 7) is driven low only on digit 0 while in RUN, as a heartbeat.

## Timing
- Reset values (all synchronous):
  - data1, data2, opcode1, opcode2, vec_count, result, flags = 0
  - state IDLE, running = 0
  - refresh counter and digit index = 0
  - step timer = 0
  - selOut = ~1 (digit 0 enabled)
  - bdOut = 8'hC0
- Reset asserted mid-RUN or mid-step: all of the above are restored on that edge. A capture pending at that edge is discarded.
- Entering RUN clears the step timer. The first advance occurs STEP_DIV cycles after the edge on which state becomes RUN. Subsequent advances follow every STEP_DIV cycles.
- Entering HOLD freezes the step timer value. Re-entering RUN clears it.
- step sampled at edge N: the vector changes at edge N+1, the capture happens at edge N+2, and the display reflects the new value from edge N+2.
- selOut and bdOut are registered and change together on the same edge. No cycle has two digits enabled.
- running is registered and equals (state == RUN).

## Test plan
Parameters for all scenarios unless stated: WIDTH=16, DIGITS=4, REFRESH_DIV=4, STEP_DIV=8. The bench models the ALU as alu_out=data1+data2.

- Reset → all outputs hold reset values, including selOut=4'b1110 and bdOut=8'hC0. Digit enables then rotate 1110→1101→1011→0111→1110, each held for 4 cycles.
- Pulse start → running=1 on the next edge. First advance 8 cycles later gives opcode1=1, vec_count=1. Advances then continue every 8 cycles. dp is low only while digit 0 is enabled.
- From IDLE pulse step three times, 10 cycles apart → opcode1=3, running=0. Result captured two edges after each step. Pulse step during RUN → ignored.
- Drive 256 steps → opcodes return to 0, data1=1, data2=3, vec_count=256. The captured result is 4, and digit 0 displays 8'h99 ("4").
- start and stop in the same cycle from IDLE → HOLD. step and stop in the same cycle → HOLD with no advance. Reset asserted mid-RUN → all outputs return to reset values on that edge.
- WIDTH=8, DIGITS=4: force result 8'hAF → digits 0..3 show 8E, 88, C0, C0.
